instr_encoder_loader: RTL and testbench

- Inverse of the core's instruction decoder: accepts structured instruction fields (format, op, registers, immediate) over a valid/ready stream.
- Packs each instruction into the 9-bit ISA word, range-checks every field, buffers words in a small FIFO and writes them sequentially into instruction memory from a programmable base address.
- Sits between the testbench/host program-load path and the instruction memory write port; used to load programs before the core is released from reset.

---
 rtl/instr_encoder_loader.sv | 179 +++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs structured instruction fields into 9-bit ISA
// words, rejects out-of-range fields, buffers words in a small FIFO and
// writes them into instruction memory starting at a programmable base.
// Optional feature macro: ENC_CHECKSUM_EN adds a running XOR checksum of
// every word written during the session.
module instr_encoder_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [2:0]        in_op,
  input  logic [3:0]        in_ra,
  input  logic [3:0]        in_rb,
  input  logic [7:0]        in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [8:0]        imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              enc_err,
  output logic              addr_wrap
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [8:0]        checksum
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [8:0] word;
    logic       bad;
  } enc_t;

  state_t                      state, state_nxt;
  logic [FIFO_DEPTH-1:0][8:0]  fifo_mem;
  logic [AW:0]                 wr_ptr, rd_ptr;
  logic                        fifo_empty, fifo_full;
  logic                        accept, push, pop, sess_start;
  enc_t                        enc;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign accept     = in_valid && in_ready;
  assign push       = accept && !enc.bad;
  assign pop        = imem_we && imem_ready;
  assign sess_start = (state == IDLE) && start;
  // Head is only presented while a write is offered; idle port reads as zero.
  assign imem_wdata = imem_we ? fifo_mem[rd_ptr[AW-1:0]] : '0;

  // Field packing and range check; unused fields of a format are ignored.
  always_comb begin
    enc = '0;
    unique case (in_fmt)
      3'd0: begin
        enc.word = {2'b00, in_op[0], in_ra[2:0], in_rb[2:0]};
        enc.bad  = (in_op > 3'd1) || (in_ra > 4'd7) || (in_rb > 4'd7);
      end
      3'd1: begin
        enc.word = {2'b01, in_op[2:0], in_ra[1:0], in_rb[1:0]};
        enc.bad  = (in_ra > 4'd3) || (in_rb > 4'd3);
      end
      3'd2: begin
        enc.word = {4'b1000, in_op[0], in_imm[3:0]};
        enc.bad  = (in_op > 3'd1) || (in_imm > 8'd15);
      end
      3'd3: begin
        enc.word = {5'b10010, in_imm[3:0]};
        enc.bad  = (in_imm > 8'd15);
      end
      3'd4: begin
        enc.word = {4'b1010, in_op[1:0], in_ra[2:0]};
        enc.bad  = (in_op > 3'd3) || (in_ra > 4'd7);
      end
      3'd5: begin
        enc.word = {4'b1011, in_op[1:0], in_ra[2:0]};
        enc.bad  = (in_op > 3'd3) || (in_ra > 4'd7);
      end
      3'd6: begin
        enc.word = {5'b11000, in_imm[3:0]};
        enc.bad  = (in_imm > 8'd15);
      end
      default: enc.bad = 1'b1;
    endcase
  end

  // Session state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and state-decoded outputs; in_ready ignores same-cycle pops.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    imem_we   = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD: begin
        in_ready = !fifo_full;
        busy     = 1'b1;
        imem_we  = !fifo_empty;
        if (in_valid && !fifo_full && in_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        imem_we = !fifo_empty;
        if (fifo_empty) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word buffer; rejected beats never reach it, reset drops its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr[AW-1:0]] <= enc.word;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Session bookkeeping: address, count and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr  <= '0;
      word_count <= '0;
      enc_err    <= 1'b0;
      addr_wrap  <= 1'b0;
    end else if (sess_start) begin
      imem_addr  <= base_addr;
      word_count <= '0;
      enc_err    <= 1'b0;
      addr_wrap  <= 1'b0;
    end else begin
      if (accept && enc.bad) enc_err <= 1'b1;
      if (pop) begin
        imem_addr  <= imem_addr + ADDR_W'(1);
        word_count <= word_count + (ADDR_W+1)'(1);
        if (&imem_addr) addr_wrap <= 1'b1;
      end
    end
  end

`ifdef ENC_CHECKSUM_EN
  // Running XOR of written words, held after the session until next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          checksum <= '0;
    else if (sess_start) checksum <= '0;
    else if (pop)        checksum <= checksum ^ imem_wdata;
  end
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: hand-computed encodings,
// addresses, flags and handshake behaviour.
module tb_instr_encoder_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_fmt = '0;
  logic [2:0] in_op = '0;
  logic [3:0] in_ra = '0;
  logic [3:0] in_rb = '0;
  logic [7:0] in_imm = '0;
  logic       in_last = 1'b0;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [8:0] imem_wdata;
  logic       imem_ready = 1'b0;
  logic       busy;
  logic       done;
  logic [8:0] word_count;
  logic       enc_err;
  logic       addr_wrap;
`ifdef ENC_CHECKSUM_EN
  logic [8:0] checksum;
`endif

  instr_encoder_loader #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_op(in_op),
    .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .busy(busy), .done(done),
    .word_count(word_count), .enc_err(enc_err), .addr_wrap(addr_wrap)
`ifdef ENC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr = 0;
  int cyc = 0;
  int acc_cnt = 0;
  logic [7:0] wa_q[$];
  logic [8:0] wd_q[$];
  int         wc_q[$];

  // Captured at the done pulse by wait_done.
  logic       d_ok, d_after, d_ee, d_aw;
  logic [8:0] d_wc;
  logic [8:0] d_cs;
  logic [7:0] a0;
  logic [8:0] d0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write and handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we && imem_ready) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      wc_q.push_back(cyc);
    end
    if (in_valid && in_ready) acc_cnt = acc_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); acc_cnt = 0;
  endtask

  task automatic do_start(input logic [7:0] base);
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [2:0] op,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic [7:0] imm, input logic last);
    logic acc;
    int n;
    acc = 1'b0; n = 0;
    in_valid = 1'b1; in_fmt = fmt; in_op = op; in_ra = ra; in_rb = rb;
    in_imm = imm; in_last = last;
    while (!acc && n < 200) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    nchecks++;
    if (!acc) begin
      nerr++;
      $display("FAIL send_accept: beat fmt%0d not accepted within 200 cycles", fmt);
    end
  endtask

  task automatic wait_done();
    d_ok = 1'b0; d_after = 1'b1; d_wc = '0; d_ee = 1'b0; d_aw = 1'b0; d_cs = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        d_ok = 1'b1; d_wc = word_count; d_ee = enc_err; d_aw = addr_wrap;
`ifdef ENC_CHECKSUM_EN
        d_cs = checksum;
`endif
        break;
      end
    end
    if (d_ok) begin
      @(negedge clk); d_after = done;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    nchecks++;
    if ({in_ready, imem_we, busy, done, enc_err, addr_wrap} !== 6'b0) begin
      nerr++; $display("FAIL reset_flags: got %b want 000000",
                       {in_ready, imem_we, busy, done, enc_err, addr_wrap});
    end
    nchecks++;
    if ({imem_addr, imem_wdata, word_count} !== 26'h0) begin
      nerr++; $display("FAIL reset_values: got addr %h data %h wc %h want 0",
                       imem_addr, imem_wdata, word_count);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    nchecks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      nerr++; $display("FAIL idle_after_reset: busy %b in_ready %b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_single();
    clear_log(); imem_ready = 1'b1;
    do_start(8'h10);
    send(3'd0, 3'd1, 4'd3, 4'd5, 8'd0, 1'b1);
    wait_done();
    nchecks++;
    if (d_ok !== 1'b1 || d_after !== 1'b0) begin
      nerr++; $display("FAIL single_done_pulse: seen %b after %b want 1 0", d_ok, d_after);
    end
    nchecks++;
    if (wa_q.size() != 1) begin
      nerr++; $display("FAIL single_writes: got %0d want 1", wa_q.size());
    end else begin
      nchecks++;
      if (wa_q[0] !== 8'h10 || wd_q[0] !== 9'b001011101) begin
        nerr++; $display("FAIL single_word: got @%h %b want @10 001011101", wa_q[0], wd_q[0]);
      end
    end
    nchecks++;
    if (d_wc !== 9'd1 || d_ee !== 1'b0) begin
      nerr++; $display("FAIL single_status: wc %0d err %b want 1 0", d_wc, d_ee);
    end
`ifdef ENC_CHECKSUM_EN
    nchecks++;
    if (d_cs !== 9'b001011101) begin
      nerr++; $display("FAIL single_checksum: got %b want 001011101", d_cs);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp6 [6];
    logic [8:0] cs;
    exp6 = '{9'b011011001, 9'b100010111, 9'b100101001,
             9'b101010110, 9'b101111001, 9'b110000100};
    clear_log(); imem_ready = 1'b1;
    do_start(8'h20);
    send(3'd1, 3'd5, 4'd2, 4'd1, 8'd0, 1'b0);
    send(3'd2, 3'd1, 4'd0, 4'd0, 8'd7, 1'b0);
    send(3'd3, 3'd0, 4'd0, 4'd0, 8'd9, 1'b0);
    send(3'd4, 3'd2, 4'd6, 4'd0, 8'd0, 1'b0);
    send(3'd5, 3'd3, 4'd1, 4'd0, 8'd0, 1'b0);
    send(3'd6, 3'd0, 4'd0, 4'd0, 8'd4, 1'b1);
    wait_done();
    nchecks++;
    if (wa_q.size() != 6) begin
      nerr++; $display("FAIL b2b_writes: got %0d want 6", wa_q.size());
    end else begin
      cs = '0;
      for (int i = 0; i < 6; i++) begin
        cs = cs ^ exp6[i];
        nchecks++;
        if (wa_q[i] !== 8'(8'h20 + i) || wd_q[i] !== exp6[i]) begin
          nerr++; $display("FAIL b2b_word%0d: got @%h %b want @%h %b",
                           i, wa_q[i], wd_q[i], 8'(8'h20 + i), exp6[i]);
        end
      end
      nchecks++;
      if (wc_q[5] - wc_q[0] != 5) begin
        nerr++; $display("FAIL b2b_no_bubbles: span %0d cycles want 5", wc_q[5] - wc_q[0]);
      end
`ifdef ENC_CHECKSUM_EN
      nchecks++;
      if (d_cs !== cs) begin
        nerr++; $display("FAIL b2b_checksum: got %b want %b", d_cs, cs);
      end
`endif
    end
    nchecks++;
    if (d_wc !== 9'd6 || d_ok !== 1'b1) begin
      nerr++; $display("FAIL b2b_status: wc %0d done %b want 6 1", d_wc, d_ok);
    end
  endtask

  task automatic test_backpressure();
    clear_log(); imem_ready = 1'b0;
    do_start(8'h40);
    fork
      begin
        for (int k = 0; k < 6; k++) send(3'd3, 3'd0, 4'd0, 4'd0, 8'(k), k == 5);
      end
      begin
        repeat (3) @(negedge clk);
        a0 = imem_addr; d0 = imem_wdata;
        repeat (7) @(negedge clk);
        nchecks++;
        if (in_ready !== 1'b0 || acc_cnt != 4) begin
          nerr++; $display("FAIL bp_full: in_ready %b accepted %0d want 0 4", in_ready, acc_cnt);
        end
        nchecks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'h40 || imem_wdata !== 9'h120) begin
          nerr++; $display("FAIL bp_head: we %b @%h %h want 1 @40 120", imem_we, imem_addr, imem_wdata);
        end
        nchecks++;
        if (imem_addr !== a0 || imem_wdata !== d0) begin
          nerr++; $display("FAIL bp_stable: @%h %h earlier @%h %h", imem_addr, imem_wdata, a0, d0);
        end
        @(posedge clk); #1 imem_ready = 1'b1;
      end
    join
    wait_done();
    nchecks++;
    if (wa_q.size() != 6) begin
      nerr++; $display("FAIL bp_writes: got %0d want 6", wa_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        nchecks++;
        if (wa_q[i] !== 8'(8'h40 + i) || wd_q[i] !== 9'(9'h120 + i)) begin
          nerr++; $display("FAIL bp_word%0d: got @%h %h want @%h %h",
                           i, wa_q[i], wd_q[i], 8'(8'h40 + i), 9'(9'h120 + i));
        end
      end
    end
  endtask

  task automatic test_errors();
    clear_log(); imem_ready = 1'b1;
    do_start(8'h50);
    send(3'd2, 3'd0, 4'd0, 4'd0, 8'd20, 1'b0);
    send(3'd7, 3'd0, 4'd0, 4'd0, 8'd0, 1'b0);
    send(3'd0, 3'd0, 4'd9, 4'd0, 8'd0, 1'b1);
    wait_done();
    nchecks++;
    if (wa_q.size() != 0) begin
      nerr++; $display("FAIL err_no_writes: got %0d want 0", wa_q.size());
    end
    nchecks++;
    if (d_ok !== 1'b1 || d_wc !== 9'd0 || d_ee !== 1'b1) begin
      nerr++; $display("FAIL err_status: done %b wc %0d err %b want 1 0 1", d_ok, d_wc, d_ee);
    end
  endtask

  task automatic test_wrap();
    clear_log(); imem_ready = 1'b1;
    do_start(8'hFE);
    send(3'd6, 3'd0, 4'd0, 4'd0, 8'd1, 1'b0);
    send(3'd6, 3'd0, 4'd0, 4'd0, 8'd2, 1'b0);
    send(3'd6, 3'd0, 4'd0, 4'd0, 8'd3, 1'b1);
    wait_done();
    nchecks++;
    if (wa_q.size() != 3) begin
      nerr++; $display("FAIL wrap_writes: got %0d want 3", wa_q.size());
    end else begin
      nchecks++;
      if (wa_q[0] !== 8'hFE || wa_q[1] !== 8'hFF || wa_q[2] !== 8'h00 || wd_q[2] !== 9'h183) begin
        nerr++; $display("FAIL wrap_addrs: got %h %h %h data %h want fe ff 00 183",
                         wa_q[0], wa_q[1], wa_q[2], wd_q[2]);
      end
    end
    nchecks++;
    if (d_aw !== 1'b1 || d_ee !== 1'b0 || d_wc !== 9'd3 || imem_addr !== 8'h01) begin
      nerr++; $display("FAIL wrap_status: wrap %b err %b wc %0d addr %h want 1 0 3 01",
                       d_aw, d_ee, d_wc, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    clear_log(); imem_ready = 1'b0;
    do_start(8'h60);
    send(3'd6, 3'd0, 4'd0, 4'd0, 8'd1, 1'b0);
    send(3'd6, 3'd0, 4'd0, 4'd0, 8'd2, 1'b0);
    send(3'd6, 3'd0, 4'd0, 4'd0, 8'd3, 1'b0);
    nchecks++;
    if (imem_we !== 1'b1) begin
      nerr++; $display("FAIL mid_pending: we %b want 1", imem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    nchecks++;
    if (imem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      nerr++; $display("FAIL mid_async_reset: we %b busy %b rdy %b want 0 0 0", imem_we, busy, in_ready);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_log(); imem_ready = 1'b1;
    do_start(8'h70);
    send(3'd6, 3'd0, 4'd0, 4'd0, 8'd5, 1'b0);
    do_start(8'h00);
    nchecks++;
    if (busy !== 1'b1) begin
      nerr++; $display("FAIL mid_start_ignored_busy: busy %b want 1", busy);
    end
    send(3'd6, 3'd0, 4'd0, 4'd0, 8'd6, 1'b1);
    wait_done();
    nchecks++;
    if (wa_q.size() != 2) begin
      nerr++; $display("FAIL mid_writes: got %0d want 2", wa_q.size());
    end else begin
      nchecks++;
      if (wa_q[0] !== 8'h70 || wa_q[1] !== 8'h71 || wd_q[0] !== 9'h185 || wd_q[1] !== 9'h186) begin
        nerr++; $display("FAIL mid_words: got @%h %h @%h %h want @70 185 @71 186",
                         wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
      end
    end
    nchecks++;
    if (d_wc !== 9'd2 || d_ok !== 1'b1) begin
      nerr++; $display("FAIL mid_status: wc %0d done %b want 2 1", d_wc, d_ok);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
